// File: rtl/rf_ctrl_pkg.sv
// Shared widths and the long-latency write-queue entry type for the
// register-file write-port control logic.
package rf_ctrl_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wq_entry_t;

endpackage

// File: rtl/rf_wq_fifo.sv
// Small FIFO of long-latency writeback entries; head is visible
// combinationally so the arbiter can write it in the same cycle it pops.
module rf_wq_fifo
  import rf_ctrl_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push_i,
  input  wq_entry_t push_entry_i,
  input  logic      pop_i,
  output logic      full_o,
  output logic      empty_o,
  output wq_entry_t head_o
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  wq_entry_t       mem_q [QDEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CW'(QDEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full queue is only legal when the head leaves this cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PW'(QDEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PW'(QDEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between the WB stage and queued
// long-latency results, and tracks registers with outstanding LU writes.
module rf_wb_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int REG_W      = rf_ctrl_pkg::REG_W,
  parameter int DATA_W     = rf_ctrl_pkg::DATA_W,
  parameter int QDEPTH     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_stall,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [REG_W-1:0]  lu_rd,
  input  logic [DATA_W-1:0] lu_data,
  input  logic              issue_valid,
  input  logic [REG_W-1:0]  issue_rd,
  output logic [31:0]       busy,
  output logic              wb_conflict,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  wq_entry_t     push_entry, head;
  logic          q_full, q_empty, q_push, q_pop;
  logic          grant_wb;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   busy_q, busy_d;

  // LU handshake: a result transfers on lu_valid && lu_ready at the posedge;
  // lu_ready is the pre-pop !full, so a full queue never accepts a result.
  assign lu_ready = !q_full;
  assign q_push   = lu_valid && lu_ready;

  assign push_entry.rd   = lu_rd;
  assign push_entry.data = lu_data;

  rf_wq_fifo #(.QDEPTH(QDEPTH)) u_wq (
    .clk          (clk),
    .reset        (reset),
    .push_i       (q_push),
    .push_entry_i (push_entry),
    .pop_i        (q_pop),
    .full_o       (q_full),
    .empty_o      (q_empty),
    .head_o       (head)
  );

  assign wb_stall = (starve_q == SW'(STARVE_MAX)) && !q_empty;

  // A forced drain beats WB; otherwise WB beats an opportunistic drain.
  assign grant_wb = !reset && !wb_stall && wb_valid;
  assign q_pop    = !reset && !q_empty && (wb_stall || !wb_valid);

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (grant_wb && (wb_rd != '0)) begin
      rf_we    = 1'b1;
      rf_waddr = wb_rd;
      rf_wdata = wb_data;
    end else if (q_pop && (head.rd != '0)) begin
      rf_we    = 1'b1;
      rf_waddr = head.rd;
      rf_wdata = head.data;
    end
  end

  assign wb_conflict = grant_wb && (wb_rd != '0) && busy_q[wb_rd];

  always_comb begin
    starve_d = starve_q;
    if (q_empty || q_pop)
      starve_d = '0;
    else if (grant_wb && (starve_q != SW'(STARVE_MAX)))
      starve_d = starve_q + 1'b1;
  end

  // Clear first so a same-cycle issue to the popped register stays busy.
  always_comb begin
    busy_d = busy_q;
    if (q_pop && (head.rd != '0))
      busy_d[head.rd] = 1'b0;
    if (issue_valid && (issue_rd != '0))
      busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  assign busy = busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
      busy_q   <= '0;
    end else begin
      starve_q <= starve_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: inputs change 1ns after each posedge,
// outputs are checked 3ns after it, well before the negedge.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [31:0] busy;
  logic        wb_conflict;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.REG_W(5), .DATA_W(32), .QDEPTH(2), .STARVE_MAX(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .wb_stall    (wb_stall),
    .lu_valid    (lu_valid),
    .lu_ready    (lu_ready),
    .lu_rd       (lu_rd),
    .lu_data     (lu_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .busy        (busy),
    .wb_conflict (wb_conflict),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk_port(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we"}, {31'd0, rf_we}, {31'd0, we});
    chk({tag, "_waddr"}, {27'd0, rf_waddr}, {27'd0, a});
    chk({tag, "_wdata"}, rf_wdata, d);
  endtask

  initial begin
    // Reset with WB requesting the port
    reset = 1'b1; wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h1234_5678;
    lu_valid = 1'b0; lu_rd = '0; lu_data = '0; issue_valid = 1'b0; issue_rd = '0;
    #3;
    chk_port("rst", 1'b0, 5'd0, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_lu_ready", {31'd0, lu_ready}, 32'd1);
    chk("rst_wb_stall", {31'd0, wb_stall}, 32'd0);
    chk("rst_conflict", {31'd0, wb_conflict}, 32'd0);
    tick(); tick();
    reset = 1'b0; wb_valid = 1'b0;
    settle();
    chk_port("post_rst", 1'b0, 5'd0, 32'd0);
    chk("post_rst_lu_ready", {31'd0, lu_ready}, 32'd1);
    chk("post_rst_busy", busy, 32'd0);

    // Simultaneous WB and LU: x7 issued first
    tick();
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    settle();
    chk("issue7_busy", busy, 32'h0000_0080);
    tick();
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h1111_1111;
    lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h2222_2222;
    settle();
    chk_port("simN", 1'b1, 5'd3, 32'h1111_1111);
    chk("simN_conflict", {31'd0, wb_conflict}, 32'd0);
    tick();
    wb_valid = 1'b0; lu_valid = 1'b0;
    settle();
    chk_port("simN1", 1'b1, 5'd7, 32'h2222_2222);
    chk("simN1_busy", busy, 32'h0000_0080);
    tick();
    settle();
    chk("simN2_busy", busy, 32'd0);
    chk_port("simN2", 1'b0, 5'd0, 32'd0);

    // Queue full with WB every cycle; starvation forces the first drain
    tick();
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h0000_0001;
    lu_valid = 1'b1; lu_rd = 5'd8; lu_data = 32'h0000_0088;
    settle();
    chk("full0_lu_ready", {31'd0, lu_ready}, 32'd1);
    chk_port("full0", 1'b1, 5'd1, 32'h0000_0001);
    tick();
    lu_rd = 5'd9; lu_data = 32'h0000_0099;
    settle();
    chk("full1_lu_ready", {31'd0, lu_ready}, 32'd1);
    chk("full1_stall", {31'd0, wb_stall}, 32'd0);
    tick();
    lu_rd = 5'd11; lu_data = 32'h0000_00BB;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("full_held_lu_ready", {31'd0, lu_ready}, 32'd0);
      chk("full_held_stall", {31'd0, wb_stall}, 32'd0);
      chk("full_held_waddr", {27'd0, rf_waddr}, 32'd1);
      tick();
    end
    settle();
    chk("full_drain_stall", {31'd0, wb_stall}, 32'd1);
    chk("full_drain_lu_ready", {31'd0, lu_ready}, 32'd0);
    chk_port("full_drain", 1'b1, 5'd8, 32'h0000_0088);
    tick();
    settle();
    chk("full_after_lu_ready", {31'd0, lu_ready}, 32'd1);
    chk("full_after_stall", {31'd0, wb_stall}, 32'd0);
    chk_port("full_after", 1'b1, 5'd1, 32'h0000_0001);
    tick();
    lu_valid = 1'b0; wb_valid = 1'b0;
    settle();
    chk_port("drain9", 1'b1, 5'd9, 32'h0000_0099);
    tick();
    settle();
    chk_port("drain11", 1'b1, 5'd11, 32'h0000_00BB);
    tick();
    settle();
    chk_port("drained", 1'b0, 5'd0, 32'd0);

    // Starvation with a single queued x10
    wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'h0000_0002;
    lu_valid = 1'b1; lu_rd = 5'd10; lu_data = 32'h0000_00A0;
    tick();
    lu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("starve_wait_stall", {31'd0, wb_stall}, 32'd0);
      chk("starve_wait_waddr", {27'd0, rf_waddr}, 32'd2);
      tick();
    end
    settle();
    chk("starve_stall", {31'd0, wb_stall}, 32'd1);
    chk_port("starve_x10", 1'b1, 5'd10, 32'h0000_00A0);
    tick();
    settle();
    chk("starve_clear_stall", {31'd0, wb_stall}, 32'd0);
    chk_port("starve_after", 1'b1, 5'd2, 32'h0000_0002);
    tick();

    // x0 handling
    wb_valid = 1'b0;
    lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'h0000_DEAD;
    tick();
    lu_valid = 1'b0;
    settle();
    chk_port("x0_pop", 1'b0, 5'd0, 32'd0);
    tick();
    lu_valid = 1'b1; lu_rd = 5'd13; lu_data = 32'h0000_00DD;
    tick();
    lu_valid = 1'b0;
    settle();
    chk_port("x0_then13", 1'b1, 5'd13, 32'h0000_00DD);
    tick();
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
    issue_valid = 1'b1; issue_rd = 5'd0;
    settle();
    chk_port("wb_x0", 1'b0, 5'd0, 32'd0);
    chk("wb_x0_conflict", {31'd0, wb_conflict}, 32'd0);
    tick();
    wb_valid = 1'b0; issue_valid = 1'b0;
    settle();
    chk("issue_x0_busy", busy, 32'd0);

    // Scoreboard set/clear collision on x5, then a conflicting WB
    issue_valid = 1'b1; issue_rd = 5'd5;
    tick();
    issue_valid = 1'b0;
    lu_valid = 1'b1; lu_rd = 5'd5; lu_data = 32'h0000_0055;
    settle();
    chk("x5_busy", busy, 32'h0000_0020);
    tick();
    lu_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd5;
    settle();
    chk_port("x5_pop", 1'b1, 5'd5, 32'h0000_0055);
    tick();
    issue_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h5555_0000;
    settle();
    chk("collide_busy", busy, 32'h0000_0020);
    chk("x5_conflict", {31'd0, wb_conflict}, 32'd1);
    chk_port("x5_wb", 1'b1, 5'd5, 32'h5555_0000);
    tick();
    wb_rd = 5'd1;
    settle();
    chk("x5_busy_kept", busy, 32'h0000_0020);
    chk("x1_no_conflict", {31'd0, wb_conflict}, 32'd0);

    // Reset mid-operation with a full queue
    lu_valid = 1'b1; lu_rd = 5'd14; lu_data = 32'h0000_00E0;
    tick();
    lu_rd = 5'd15; lu_data = 32'h0000_00F0;
    tick();
    lu_valid = 1'b0;
    settle();
    chk("pre_rst_lu_ready", {31'd0, lu_ready}, 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 32'd0);
    chk("mid_rst_lu_ready", {31'd0, lu_ready}, 32'd1);
    chk("mid_rst_stall", {31'd0, wb_stall}, 32'd0);
    chk_port("mid_rst", 1'b0, 5'd0, 32'd0);
    tick();
    reset = 1'b0; wb_valid = 1'b0;
    settle();
    chk_port("after_mid_rst", 1'b0, 5'd0, 32'd0);
    tick();
    settle();
    chk_port("after_mid_rst2", 1'b0, 5'd0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter and scoreboard for the 32x32 register file. Shares the register file's single write port between the in-order pipeline writeback stage and the long-latency execution unit (mul/div). Buffers long-latency results in a small queue and tracks registers with outstanding long-latency writes so the hazard unit can stall dependents. Sits between the WB stage / long-latency unit and the register file write port.

## Interface
- `REG_W`, default 5: register address width.
- `DATA_W`, default 32: data width.
- `QDEPTH`, default 2: long-latency result queue depth; must be 2 or greater.
- `STARVE_MAX`, default 4: consecutive deferred cycles before the arbiter forces a queue drain.

- `clk`, in, 1: clock; all state updates on the posedge.
- `reset`, in, 1: reset, asynchronous, active-high.
- `wb_valid`, in, 1: pipeline writeback valid.
- `wb_rd`, in, REG_W: pipeline writeback destination.
- `wb_data`, in, DATA_W: pipeline writeback data.
- `wb_stall`, out, 1: WB must hold this cycle; `wb_valid` is ignored while this is high.
- `lu_valid`, in, 1: long-latency result valid.
- `lu_ready`, out, 1: queue can accept a result (`!full`).
- `lu_rd`, in, REG_W: long-latency result destination.
- `lu_data`, in, DATA_W: long-latency result data.
- `issue_valid`, in, 1: long-latency op issued; marks `issue_rd` busy.
- `issue_rd`, in, REG_W: destination of the issued op.
- `busy`, out, 32: per-register outstanding long-latency write flag; bit 0 is always 0.
- `wb_conflict`, out, 1: pulse when an accepted WB targets a busy register.
- `rf_we`, out, 1: register file write enable.
- `rf_waddr`, out, REG_W: register file write address.
- `rf_wdata`, out, DATA_W: register file write data.

## Operation
- A LU push occurs on `lu_valid && lu_ready`; the entry is written into the queue at the posedge.
- `wb_stall` is high when the starve counter equals STARVE_MAX and the queue is non-empty.
- **Write-port select** (combinational, evaluated in priority order):
  - `reset` asserted: `rf_we=0`.
  - Else if `wb_stall`: drain the queue head.
  - Else if `wb_valid`: write from WB.
  - Else if the queue is non-empty: drain the queue head.
  - Else: `rf_we=0`.
- **x0 writes:**
  - WB or head entry with rd=0: `rf_we=0`.
  - A head entry with rd=0 is still popped, and it still counts as the port use for that cycle.
- **Queue:**
  - FIFO, QDEPTH entries.
  - Push and pop in the same cycle are allowed, including when full; `lu_ready` reflects pre-pop state, so a full queue still reports `lu_ready=0`.
  - Pointers wrap modulo QDEPTH.
- **Starve counter:**
  - Increments in each cycle where the queue is non-empty and WB wins the port.
  - Clears on any queue pop, and whenever the queue is empty.
  - Saturates at STARVE_MAX.
- **Scoreboard:**
  - `issue_valid` with rd≠0 sets `busy[issue_rd]` at the posedge.
  - A queue pop with rd≠0 clears `busy[rd]`.
  - Same register set and cleared in one cycle: set wins.
- **`wb_conflict`:**
  - Combinational; high when WB is granted with rd≠0 and `busy[wb_rd]` is set.
  - The WB write still happens, and `busy` is unchanged.

## Timing
- Reset values:
  - Queue empty, busy=0, starve counter=0.
  - `lu_ready=1`, `wb_stall=0`, `rf_we=0`, `wb_conflict=0`.
  - `rf_waddr` and `rf_wdata` are 0 whenever `rf_we=0`.
- WB latency is 0: `rf_we` is driven in the same cycle as `wb_valid`. The register file captures the write on the following negedge.
- LU latency:
  - A result pushed at posedge N can be written at the earliest in cycle N+1.
  - Its `busy` bit clears at the posedge ending that write cycle.
- Worst-case LU drain delay with a stream of WB writes is STARVE_MAX+1 cycles.
- Reset mid-operation:
  - Queued results are discarded and all busy bits cleared asynchronously.
  - No `rf_we` is issued while `reset` is high.

## Structure
- Package `rf_ctrl_pkg` holds:
  - `REG_W` and `DATA_W` constants.
  - `wq_entry_t` struct {rd, data}.
- Sub-module `rf_wq_fifo`: parameterised QDEPTH FIFO of `wq_entry_t`, providing push, pop, full, empty and head.
- Arbitration, starve counter and scoreboard live in the top level.

## Test plan
- **Reset:** assert `reset` with `wb_valid=1` -> `rf_we=0`, `busy=0`, `lu_ready=1`; after release, all outputs hold their reset values.
- **Simultaneous WB and LU:** in cycle N, WB x3=0x11111111 and push LU x7=0x22222222 (x7 issued earlier) ->
  - Cycle N writes x3.
  - Cycle N+1 writes x7.
  - `busy[7]` drops at the end of N+1.
- **Queue full:** QDEPTH=2, WB valid every cycle, push LU x8 and x9 -> `lu_ready=0` after the second push; a third `lu_valid` is held off until the first pop.
- **Starvation:** WB valid every cycle with one queued entry x10 -> `wb_stall=1` on the 5th cycle (counter=4), x10 written in that cycle, counter cleared.
- **x0 handling:**
  - LU result rd=0 -> popped with `rf_we=0`.
  - WB rd=0 -> `rf_we=0`.
  - `issue_rd=0` -> `busy[0]` stays 0.
- **Scoreboard set/clear collision:** issue x5 in the same cycle that a queued x5 pops -> `busy[5]=1` afterwards. A later WB to x5 -> `wb_conflict=1` for that cycle.
